rob_ptr_ctrl: RTL and testbench
===============================

ROB_PTR_CTRL -- requirements
Module: rob_ptr_ctrl

Interface
REQ-001 SHALL expose: clk  input  1  single clock, all state on rising edge.
REQ-002 SHALL expose: rst_n  input  1  asynchronous reset, active-high (1 = reset asserted).
REQ-003 SHALL expose: flush  input  1  pipeline flush, empties ROB.
REQ-004 SHALL expose: alloc_en  input  1  stage-5 write strobe (issued when wr_pause=0).
REQ-005 SHALL expose: wr_ROB_num  input  3  entries to allocate, 0..4.
REQ-006 SHALL expose: alloc_except  input  12  four 3-bit except codes, slot k at [3k+2:3k], compacted in allocation order.
REQ-007 SHALL expose: wbN_vld / wbN_ROB_ID / wbN_except  input  1/6/3  writeback ports N=0..3 (ALU0, ALU1, AGU, BRU).
REQ-008 SHALL expose: ROB_wr_ptr_exp  output  7  allocation pointer, bit 6 = wrap bit.
REQ-009 SHALL expose: ROB_rd_ptr_exp  output  7  commit pointer, bit 6 = wrap bit.
REQ-010 SHALL expose: ROB_room  output  7  free entries, 0..64.
REQ-011 SHALL expose: commit_num  output  3  entries committing this cycle, 0..4.
REQ-012 SHALL expose: commit_except_vld / commit_except_code  output  1/3  head exception commit.

Function
REQ-013 SHALL hold 64 entries, each with valid, complete, except[2:0].
REQ-014 SHALL compute occupancy = (wr_ptr_exp - rd_ptr_exp) mod 128; ROB_room = 64 - occupancy.
REQ-015 On alloc_en with wr_ROB_num <= ROB_room, SHALL set entries wr_ptr..wr_ptr+num-1 (index mod 64) valid, except from alloc_except, complete = (except != 0); wr_ptr_exp += num next edge.
REQ-016 SHALL ignore alloc_en when wr_ROB_num > ROB_room (no entry or pointer change).
REQ-017 SHALL, per writeback port with vld=1 and target entry valid, set complete=1 and OR in wbN_except; writes to invalid entries ignored.
REQ-018 SHALL compute combinationally commit_num = count of consecutive head entries (max 4, max occupancy) that are valid, complete, except=0.
REQ-019 If commit_num=0 and head entry is valid, complete, except!=0: commit_except_vld=1, commit_except_code=head except, head counts as one committed entry.
REQ-020 Exception entry behind normal completed entries SHALL commit alone on a later cycle; normals commit first.
REQ-021 Committed entries SHALL clear valid; rd_ptr_exp advances by committed count next edge.
REQ-022 Allocation and commit in the same cycle SHALL both take effect; occupancy updates by alloc - commit.
REQ-023 Writeback in the cycle an entry commits is irrelevant (entry already complete); writeback to an entry allocated the same cycle is ignored.
REQ-024 Pointer wrap: 7-bit increments wrap 127->0; full = occupancy 64 (index equal, wrap bits differ); empty = pointers equal.
REQ-025 flush SHALL take priority: next edge clears all valid/complete, sets both pointers to 0, ignores alloc, writeback, commit; commit outputs forced 0 during flush.

Reset
REQ-026 rst_n=1 SHALL asynchronously clear all entry state, pointers to 7'd0; ROB_room=64, commit_num=0, commit_except_vld=0, commit_except_code=0.
REQ-027 Reset mid-operation SHALL discard in-flight allocation and commit in that cycle.

Configuration
REQ-028 Macro ROB_ROOM_BYPASS_EN: defined -> ROB_room = 64 - occupancy + commit count of current cycle (same-cycle freed entries usable by stage 5); undefined -> ROB_room from registered pointers only.
REQ-029 With ROB_ROOM_BYPASS_EN defined, allocation into an entry committing the same cycle SHALL write the new entry (allocation wins over commit clear).

Verification
REQ-030 Reset, alloc_en=1 num=4 except=0 -> wr_ptr_exp=4, room=60, commit_num=0.
REQ-031 Entries 0..3 allocated, wb to IDs 0,1,3 -> commit_num=2, then rd_ptr_exp=2; wb ID 2 -> commit_num=2, rd_ptr_exp=4.
REQ-032 Allocate 2 with slot1 except=3'b010, wb ID0 -> cycle A commit_num=1; cycle B commit_except_vld=1, code=2, rd_ptr advances 1.
REQ-033 Fill 64 entries -> room=0, wr_ptr_exp=64; alloc num=1 ignored; commit 4 and realloc past 127 -> pointers wrap to 0..3 correctly.
REQ-034 Full ROB, head 4 complete, alloc num=4 same cycle -> without macro alloc ignored; with ROB_ROOM_BYPASS_EN alloc accepted, room stays 0.
REQ-035 Mid-stream flush with alloc and wb asserted -> next cycle pointers 0, room=64, commit_num=0.

Source files
------------

// File: rtl/rob_ptr_ctrl.sv
// rob_ptr_ctrl: 64-entry reorder buffer allocation/commit pointer controller.
// Tracks valid/complete/except per entry, up to 4 allocs and 4 commits per cycle.
// Optional feature macro: ROB_ROOM_BYPASS_EN -- ROB_room also counts entries
// freed by this cycle's commit, so stage 5 may reuse them immediately.
module rob_ptr_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        alloc_en,
  input  logic [2:0]  wr_ROB_num,
  input  logic [11:0] alloc_except,
  input  logic        wb0_vld,
  input  logic [5:0]  wb0_ROB_ID,
  input  logic [2:0]  wb0_except,
  input  logic        wb1_vld,
  input  logic [5:0]  wb1_ROB_ID,
  input  logic [2:0]  wb1_except,
  input  logic        wb2_vld,
  input  logic [5:0]  wb2_ROB_ID,
  input  logic [2:0]  wb2_except,
  input  logic        wb3_vld,
  input  logic [5:0]  wb3_ROB_ID,
  input  logic [2:0]  wb3_except,
  output logic [6:0]  ROB_wr_ptr_exp,
  output logic [6:0]  ROB_rd_ptr_exp,
  output logic [6:0]  ROB_room,
  output logic [2:0]  commit_num,
  output logic        commit_except_vld,
  output logic [2:0]  commit_except_code
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IW    = 6;
  localparam int unsigned PW    = 7;
  localparam int unsigned XW    = 3;
  localparam int unsigned NPORT = 4;

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] complete_q;
  logic [XW-1:0]    exc_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;

  logic             wb_vld [NPORT];
  logic [IW-1:0]    wb_id  [NPORT];
  logic [XW-1:0]    wb_exc [NPORT];
  logic [DEPTH-1:0] wb_hit;
  logic [XW-1:0]    wb_or  [DEPTH];

  logic [PW-1:0]    occ;
  logic [IW-1:0]    head;
  logic [IW-1:0]    scan_idx;
  logic             scan_stop;
  logic [2:0]       norm_cnt;
  logic             head_exc;
  logic [2:0]       free_cnt;
  logic [PW-1:0]    room;
  logic             alloc_ok;

  assign wb_vld[0] = wb0_vld;  assign wb_id[0] = wb0_ROB_ID;  assign wb_exc[0] = wb0_except;
  assign wb_vld[1] = wb1_vld;  assign wb_id[1] = wb1_ROB_ID;  assign wb_exc[1] = wb1_except;
  assign wb_vld[2] = wb2_vld;  assign wb_id[2] = wb2_ROB_ID;  assign wb_exc[2] = wb2_except;
  assign wb_vld[3] = wb3_vld;  assign wb_id[3] = wb3_ROB_ID;  assign wb_exc[3] = wb3_except;

  assign occ  = wr_ptr_q - rd_ptr_q;
  assign head = rd_ptr_q[IW-1:0];

  // Merge all writeback ports per entry so two ports hitting one ID both OR in.
  always_comb begin
    wb_hit = '0;
    for (int e = 0; e < DEPTH; e++) wb_or[e] = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (wb_vld[p]) begin
        wb_hit[wb_id[p]] = 1'b1;
        wb_or[wb_id[p]]  = wb_or[wb_id[p]] | wb_exc[p];
      end
    end
  end

  // Count the run of clean completed head entries; lone exception head otherwise.
  always_comb begin
    norm_cnt  = '0;
    head_exc  = 1'b0;
    scan_stop = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NPORT; i++) begin
      scan_idx = head + IW'(i);
      if (!scan_stop && (PW'(i) < occ) && valid_q[scan_idx] &&
          complete_q[scan_idx] && (exc_q[scan_idx] == '0))
        norm_cnt = norm_cnt + 3'd1;
      else
        scan_stop = 1'b1;
    end
    if ((norm_cnt == '0) && (occ != '0) && valid_q[head] && complete_q[head] &&
        (exc_q[head] != '0))
      head_exc = 1'b1;
    if (flush) begin
      norm_cnt = '0;
      head_exc = 1'b0;
    end
  end

  assign free_cnt = head_exc ? 3'd1 : norm_cnt;

`ifdef ROB_ROOM_BYPASS_EN
  assign room = PW'(DEPTH) - occ + PW'(free_cnt);
`else
  assign room = PW'(DEPTH) - occ;
`endif

  assign alloc_ok = alloc_en && !flush && (wr_ROB_num <= 3'd4) && (PW'(wr_ROB_num) <= room);

  assign ROB_wr_ptr_exp     = wr_ptr_q;
  assign ROB_rd_ptr_exp     = rd_ptr_q;
  assign ROB_room           = room;
  assign commit_num         = norm_cnt;
  assign commit_except_vld  = head_exc;
  assign commit_except_code = head_exc ? exc_q[head] : '0;

  // Entry state: writeback, then commit clear, then allocation (allocation wins).
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_q    <= '0;
      complete_q <= '0;
      for (int e = 0; e < DEPTH; e++) exc_q[e] <= '0;
    end else if (flush) begin
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (wb_hit[e] && valid_q[e]) begin
          complete_q[e] <= 1'b1;
          exc_q[e]      <= exc_q[e] | wb_or[e];
        end
      end
      for (int i = 0; i < NPORT; i++) begin
        if (3'(i) < free_cnt) begin
          valid_q[head + IW'(i)]    <= 1'b0;
          complete_q[head + IW'(i)] <= 1'b0;
        end
      end
      if (alloc_ok) begin
        for (int k = 0; k < NPORT; k++) begin
          if (3'(k) < wr_ROB_num) begin
            valid_q[wr_ptr_q[IW-1:0] + IW'(k)]    <= 1'b1;
            exc_q[wr_ptr_q[IW-1:0] + IW'(k)]      <= alloc_except[XW*k +: XW];
            complete_q[wr_ptr_q[IW-1:0] + IW'(k)] <= |alloc_except[XW*k +: XW];
          end
        end
      end
    end
  end

  // Wrap-bit pointers advance by accepted allocs and committed entries.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + (alloc_ok ? PW'(wr_ROB_num) : PW'(0));
      rd_ptr_q <= rd_ptr_q + PW'(free_cnt);
    end
  end

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// tb_rob_ptr_ctrl: directed and randomized checks of rob_ptr_ctrl against a
// queue-based ROB model (head of queue = oldest entry).
module tb_rob_ptr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        alloc_en;
  logic [2:0]  num;
  logic [11:0] aexc;
  logic        wb_vld [4];
  logic [5:0]  wb_id  [4];
  logic [2:0]  wb_exc [4];
  logic [6:0]  wr_ptr, rd_ptr, room;
  logic [2:0]  cnum;
  logic        exv;
  logic [2:0]  ecode;

  int vectors = 0;
  int errors  = 0;

  typedef struct {bit comp; bit [2:0] exc;} ent_t;
  ent_t q[$];
  int   m_wr, m_rd;
  int   e_num, e_free, e_room;
  bit   e_exv;
  bit [2:0] e_code;

`ifdef ROB_ROOM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rob_ptr_ctrl dut (
    .clk(clk), .rst_n(rst), .flush(flush), .alloc_en(alloc_en),
    .wr_ROB_num(num), .alloc_except(aexc),
    .wb0_vld(wb_vld[0]), .wb0_ROB_ID(wb_id[0]), .wb0_except(wb_exc[0]),
    .wb1_vld(wb_vld[1]), .wb1_ROB_ID(wb_id[1]), .wb1_except(wb_exc[1]),
    .wb2_vld(wb_vld[2]), .wb2_ROB_ID(wb_id[2]), .wb2_except(wb_exc[2]),
    .wb3_vld(wb_vld[3]), .wb3_ROB_ID(wb_id[3]), .wb3_except(wb_exc[3]),
    .ROB_wr_ptr_exp(wr_ptr), .ROB_rd_ptr_exp(rd_ptr), .ROB_room(room),
    .commit_num(cnum), .commit_except_vld(exv), .commit_except_code(ecode)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Expected combinational outputs from the current model contents and inputs.
  task automatic predict();
    int n = 0;
    e_exv  = 1'b0;
    e_code = 3'd0;
    while (n < 4 && n < q.size() && q[n].comp && q[n].exc == 3'd0) n++;
    if (n == 0 && q.size() > 0 && q[0].comp && q[0].exc != 3'd0) begin
      e_exv  = 1'b1;
      e_code = q[0].exc;
    end
    if (flush) begin
      n = 0; e_exv = 1'b0; e_code = 3'd0;
    end
    e_num  = n;
    e_free = e_exv ? 1 : n;
    e_room = 64 - q.size() + (BYP ? e_free : 0);
  endtask

  // Apply one clock edge's worth of ROB behaviour to the model.
  task automatic model_step();
    ent_t t;
    int   pos;
    predict();
    if (flush) begin
      q.delete(); m_wr = 0; m_rd = 0;
      return;
    end
    for (int p = 0; p < 4; p++) begin
      if (wb_vld[p]) begin
        pos = (int'(wb_id[p]) - m_rd) & 63;
        if (pos < q.size()) begin
          q[pos].comp = 1'b1;
          q[pos].exc  = q[pos].exc | wb_exc[p];
        end
      end
    end
    for (int f = 0; f < e_free; f++) void'(q.pop_front());
    m_rd = (m_rd + e_free) % 128;
    if (alloc_en && num <= 3'd4 && int'(num) <= e_room) begin
      for (int k = 0; k < int'(num); k++) begin
        t.exc  = aexc[3*k +: 3];
        t.comp = (t.exc != 3'd0);
        q.push_back(t);
      end
      m_wr = (m_wr + int'(num)) % 128;
    end
  endtask

  task automatic idle();
    flush = 1'b0; alloc_en = 1'b0; num = 3'd0; aexc = 12'd0;
    for (int p = 0; p < 4; p++) begin
      wb_vld[p] = 1'b0; wb_id[p] = 6'd0; wb_exc[p] = 3'd0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    q.delete(); m_wr = 0; m_rd = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pick_oldest_wb();
    int n = 0;
    for (int p = 0; p < 4; p++) begin
      wb_vld[p] = 1'b0; wb_id[p] = 6'd0; wb_exc[p] = 3'd0;
    end
    for (int i = 0; i < q.size() && n < 4; i++) begin
      if (!q[i].comp) begin
        wb_vld[n] = 1'b1; wb_id[n] = 6'((m_rd + i) & 63); n++;
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #3;
    vectors++; if (wr_ptr !== 7'd0) begin errors++; $display("FAIL reset_wr: got %0d want 0", wr_ptr); end
    vectors++; if (rd_ptr !== 7'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_ptr); end
    vectors++; if (room !== 7'd64) begin errors++; $display("FAIL reset_room: got %0d want 64", room); end
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL reset_cnum: got %0d want 0", cnum); end
    vectors++; if (exv !== 1'b0) begin errors++; $display("FAIL reset_exv: got %0d want 0", exv); end
    vectors++; if (ecode !== 3'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", ecode); end
    @(negedge clk);
    rst = 1'b0;
    q.delete(); m_wr = 0; m_rd = 0;
  endtask

  task automatic test_alloc_and_partial_wb();
    do_reset();
    alloc_en = 1'b1; num = 3'd4; aexc = 12'd0;
    tick(); idle(); #1;
    vectors++; if (wr_ptr !== 7'd4) begin errors++; $display("FAIL alloc_wr: got %0d want 4", wr_ptr); end
    vectors++; if (room !== 7'd60) begin errors++; $display("FAIL alloc_room: got %0d want 60", room); end
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL alloc_cnum: got %0d want 0", cnum); end
    wb_vld[0] = 1'b1; wb_id[0] = 6'd0;
    wb_vld[1] = 1'b1; wb_id[1] = 6'd1;
    wb_vld[2] = 1'b1; wb_id[2] = 6'd3;
    tick(); idle(); #1;
    vectors++; if (cnum !== 3'd2) begin errors++; $display("FAIL partial_cnum: got %0d want 2", cnum); end
    tick(); #1;
    vectors++; if (rd_ptr !== 7'd2) begin errors++; $display("FAIL partial_rd: got %0d want 2", rd_ptr); end
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL partial_stall: got %0d want 0", cnum); end
    wb_vld[0] = 1'b1; wb_id[0] = 6'd2;
    tick(); idle(); #1;
    vectors++; if (cnum !== 3'd2) begin errors++; $display("FAIL fill_gap_cnum: got %0d want 2", cnum); end
    tick(); #1;
    vectors++; if (rd_ptr !== 7'd4) begin errors++; $display("FAIL fill_gap_rd: got %0d want 4", rd_ptr); end
    vectors++; if (room !== 7'd64) begin errors++; $display("FAIL fill_gap_room: got %0d want 64", room); end
  endtask

  task automatic test_exception();
    do_reset();
    alloc_en = 1'b1; num = 3'd2; aexc = 12'h010;
    tick(); idle();
    wb_vld[0] = 1'b1; wb_id[0] = 6'd0;
    tick(); idle(); #1;
    vectors++; if (cnum !== 3'd1) begin errors++; $display("FAIL exc_a_cnum: got %0d want 1", cnum); end
    vectors++; if (exv !== 1'b0) begin errors++; $display("FAIL exc_a_vld: got %0d want 0", exv); end
    tick(); #1;
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL exc_b_cnum: got %0d want 0", cnum); end
    vectors++; if (exv !== 1'b1) begin errors++; $display("FAIL exc_b_vld: got %0d want 1", exv); end
    vectors++; if (ecode !== 3'd2) begin errors++; $display("FAIL exc_b_code: got %0d want 2", ecode); end
    vectors++; if (rd_ptr !== 7'd1) begin errors++; $display("FAIL exc_b_rd: got %0d want 1", rd_ptr); end
    tick(); #1;
    vectors++; if (rd_ptr !== 7'd2) begin errors++; $display("FAIL exc_after_rd: got %0d want 2", rd_ptr); end
    vectors++; if (exv !== 1'b0) begin errors++; $display("FAIL exc_after_vld: got %0d want 0", exv); end
  endtask

  task automatic test_full_wrap();
    bit wrapped = 1'b0;
    int prev;
    int extra = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      alloc_en = 1'b1; num = 3'd4; aexc = 12'd0;
      tick();
    end
    idle(); #1;
    vectors++; if (room !== 7'd0) begin errors++; $display("FAIL full_room: got %0d want 0", room); end
    vectors++; if (wr_ptr !== 7'd64) begin errors++; $display("FAIL full_wr: got %0d want 64", wr_ptr); end
    alloc_en = 1'b1; num = 3'd1;
    tick(); idle(); #1;
    vectors++; if (wr_ptr !== 7'd64) begin errors++; $display("FAIL full_reject_wr: got %0d want 64", wr_ptr); end
    for (int c = 0; c < 300 && extra < 6; c++) begin
      alloc_en = 1'b1; num = 3'd4; aexc = 12'd0;
      pick_oldest_wb();
      #1;
      predict();
      vectors++; if (wr_ptr !== 7'(m_wr)) begin errors++; $display("FAIL wrap_wr: got %0d want %0d", wr_ptr, m_wr); end
      vectors++; if (rd_ptr !== 7'(m_rd)) begin errors++; $display("FAIL wrap_rd: got %0d want %0d", rd_ptr, m_rd); end
      vectors++; if (room !== 7'(e_room)) begin errors++; $display("FAIL wrap_room: got %0d want %0d", room, e_room); end
      vectors++; if (cnum !== 3'(e_num)) begin errors++; $display("FAIL wrap_cnum: got %0d want %0d", cnum, e_num); end
      prev = m_wr;
      tick();
      if (m_wr < prev) wrapped = 1'b1;
      if (wrapped) extra++;
    end
    idle(); #1;
    vectors++; if (!wrapped) begin errors++; $display("FAIL wrap_reached: got no wrap want wrap within 300 cycles"); end
    vectors++; if (wr_ptr !== 7'(m_wr)) begin errors++; $display("FAIL wrap_final_wr: got %0d want %0d", wr_ptr, m_wr); end
  endtask

  task automatic test_bypass();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      alloc_en = 1'b1; num = 3'd4; aexc = 12'd0;
      tick();
    end
    idle();
    for (int p = 0; p < 4; p++) begin
      wb_vld[p] = 1'b1; wb_id[p] = 6'(p);
    end
    tick(); idle();
    alloc_en = 1'b1; num = 3'd4;
    #1;
    vectors++; if (cnum !== 3'd4) begin errors++; $display("FAIL byp_cnum: got %0d want 4", cnum); end
    vectors++; if (room !== (BYP ? 7'd4 : 7'd0)) begin errors++; $display("FAIL byp_room_pre: got %0d want %0d", room, BYP ? 4 : 0); end
    tick(); idle(); #1;
    vectors++; if (rd_ptr !== 7'd4) begin errors++; $display("FAIL byp_rd: got %0d want 4", rd_ptr); end
    vectors++; if (wr_ptr !== (BYP ? 7'd68 : 7'd64)) begin errors++; $display("FAIL byp_wr: got %0d want %0d", wr_ptr, BYP ? 68 : 64); end
    vectors++; if (room !== (BYP ? 7'd0 : 7'd4)) begin errors++; $display("FAIL byp_room_post: got %0d want %0d", room, BYP ? 0 : 4); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_en = 1'b1; num = 3'd4;
    tick(); idle();
    wb_vld[0] = 1'b1; wb_id[0] = 6'd0;
    wb_vld[1] = 1'b1; wb_id[1] = 6'd1;
    tick(); idle();
    flush = 1'b1; alloc_en = 1'b1; num = 3'd3;
    wb_vld[0] = 1'b1; wb_id[0] = 6'd2;
    #1;
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL flush_cnum_forced: got %0d want 0", cnum); end
    vectors++; if (exv !== 1'b0) begin errors++; $display("FAIL flush_exv_forced: got %0d want 0", exv); end
    tick(); idle(); #1;
    vectors++; if (wr_ptr !== 7'd0) begin errors++; $display("FAIL flush_wr: got %0d want 0", wr_ptr); end
    vectors++; if (rd_ptr !== 7'd0) begin errors++; $display("FAIL flush_rd: got %0d want 0", rd_ptr); end
    vectors++; if (room !== 7'd64) begin errors++; $display("FAIL flush_room: got %0d want 64", room); end
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL flush_cnum: got %0d want 0", cnum); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_en = 1'b1; num = 3'd4;
    tick();
    wb_vld[0] = 1'b1; wb_id[0] = 6'd0;
    #2 rst = 1'b1;
    #1;
    vectors++; if (wr_ptr !== 7'd0) begin errors++; $display("FAIL midrst_wr: got %0d want 0", wr_ptr); end
    vectors++; if (room !== 7'd64) begin errors++; $display("FAIL midrst_room: got %0d want 64", room); end
    @(negedge clk);
    rst = 1'b0; idle();
    q.delete(); m_wr = 0; m_rd = 0;
    tick(); #1;
    vectors++; if (wr_ptr !== 7'd0) begin errors++; $display("FAIL midrst_after_wr: got %0d want 0", wr_ptr); end
    vectors++; if (cnum !== 3'd0) begin errors++; $display("FAIL midrst_after_cnum: got %0d want 0", cnum); end
  endtask

  task automatic test_random();
    int wb_pct;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      wb_pct = (c < 800) ? 30 : 65;
      flush    = ($urandom_range(0, 199) == 0);
      alloc_en = ($urandom_range(0, 99) < 70);
      num      = 3'($urandom_range(0, 4));
      for (int k = 0; k < 4; k++)
        aexc[3*k +: 3] = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      for (int p = 0; p < 4; p++) begin
        wb_vld[p] = ($urandom_range(0, 99) < wb_pct);
        if (q.size() > 0 && $urandom_range(0, 7) != 0)
          wb_id[p] = 6'((m_rd + int'($urandom_range(0, q.size() - 1))) & 63);
        else
          wb_id[p] = 6'($urandom_range(0, 63));
        wb_exc[p] = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      end
      #1;
      predict();
      vectors++; if (wr_ptr !== 7'(m_wr)) begin errors++; $display("FAIL rnd_wr c=%0d: got %0d want %0d", c, wr_ptr, m_wr); end
      vectors++; if (rd_ptr !== 7'(m_rd)) begin errors++; $display("FAIL rnd_rd c=%0d: got %0d want %0d", c, rd_ptr, m_rd); end
      vectors++; if (room !== 7'(e_room)) begin errors++; $display("FAIL rnd_room c=%0d: got %0d want %0d", c, room, e_room); end
      vectors++; if (cnum !== 3'(e_num)) begin errors++; $display("FAIL rnd_cnum c=%0d: got %0d want %0d", c, cnum, e_num); end
      vectors++; if (exv !== e_exv) begin errors++; $display("FAIL rnd_exv c=%0d: got %0d want %0d", c, exv, e_exv); end
      vectors++; if (ecode !== e_code) begin errors++; $display("FAIL rnd_code c=%0d: got %0d want %0d", c, ecode, e_code); end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_alloc_and_partial_wb();
    test_exception();
    test_full_wrap();
    test_bypass();
    test_flush();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
